// File: rtl/stage_e_pkg.sv
// Shared encodings for the execute stage: ALU ops, MDU ops, result select and forwarding select.
package stage_e_pkg;

    localparam int unsigned ALU_OP_W  = 4;
    localparam int unsigned MDU_OP_W  = 3;
    localparam int unsigned RES_SEL_W = 2;
    localparam int unsigned FWD_SEL_W = 2;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_NOR  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SLLV = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SRLV = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_SRAV = 4'd10;
    localparam logic [ALU_OP_W-1:0] ALU_LUI  = 4'd11;

    localparam logic [MDU_OP_W-1:0] MDU_NONE  = 3'd0;
    localparam logic [MDU_OP_W-1:0] MDU_MULT  = 3'd1;
    localparam logic [MDU_OP_W-1:0] MDU_MULTU = 3'd2;
    localparam logic [MDU_OP_W-1:0] MDU_DIV   = 3'd3;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 3'd4;
    localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 3'd5;
    localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 3'd6;

    localparam logic [RES_SEL_W-1:0] RES_ALU = 2'b00;
    localparam logic [RES_SEL_W-1:0] RES_HI  = 2'b01;
    localparam logic [RES_SEL_W-1:0] RES_LO  = 2'b10;

    localparam logic [FWD_SEL_W-1:0] FWD_RD = 2'b00;
    localparam logic [FWD_SEL_W-1:0] FWD_W  = 2'b01;
    localparam logic [FWD_SEL_W-1:0] FWD_M  = 2'b10;

    // Ops that occupy the multi-cycle datapath and raise Busy.
    function automatic logic is_mdu_start(input logic [MDU_OP_W-1:0] op);
        return op inside {[MDU_MULT:MDU_DIVU]};
    endfunction

endpackage

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit: operand latches, cycle counter, HI/LO registers and Busy.
module mdu_unit
    import stage_e_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_e,
    input  logic [MDU_OP_W-1:0] mdu_op,
    input  logic [WIDTH-1:0]    op_a,
    input  logic [WIDTH-1:0]    op_b,
    output logic [WIDTH-1:0]    hi,
    output logic [WIDTH-1:0]    lo,
    output logic                busy
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    logic [WIDTH-1:0]    a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [MDU_OP_W-1:0] op_q, op_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                start_c;

    logic [2*WIDTH-1:0]  prod_s, prod_u;
    logic [WIDTH-1:0]    a_abs, b_abs, b_abs_nz, b_nz;
    logic [WIDTH-1:0]    quot_mag, rem_mag, quot_s, rem_s, quot_u, rem_u;
    logic                a_neg, b_neg;

    assign start_c = reset && valid_e && !busy_q && is_mdu_start(mdu_op);

    // Result datapath; signed divide works on magnitudes so MIN / -1 wraps back to MIN.
    always_comb begin
        a_neg    = a_q[WIDTH-1];
        b_neg    = b_q[WIDTH-1];
        prod_s   = {{WIDTH{a_neg}}, a_q} * {{WIDTH{b_neg}}, b_q};
        prod_u   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        a_abs    = a_neg ? -a_q : a_q;
        b_abs    = b_neg ? -b_q : b_q;
        b_abs_nz = (b_abs == '0) ? WIDTH'(1) : b_abs;
        b_nz     = (b_q == '0) ? WIDTH'(1) : b_q;
        quot_mag = a_abs / b_abs_nz;
        rem_mag  = a_abs % b_abs_nz;
        quot_s   = (a_neg ^ b_neg) ? -quot_mag : quot_mag;
        rem_s    = a_neg ? -rem_mag : rem_mag;
        quot_u   = a_q / b_nz;
        rem_u    = a_q % b_nz;
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        op_d  = op_q;
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (start_c) begin
            a_d   = op_a;
            b_d   = op_b;
            op_d  = mdu_op;
            cnt_d = (mdu_op == MDU_MULT || mdu_op == MDU_MULTU) ?
                    CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                case (op_q)
                    MDU_MULT:  {hi_d, lo_d} = prod_s;
                    MDU_MULTU: {hi_d, lo_d} = prod_u;
                    MDU_DIV:   if (b_q != '0) begin hi_d = rem_s; lo_d = quot_s; end
                    MDU_DIVU:  if (b_q != '0) begin hi_d = rem_u; lo_d = quot_u; end
                    default: ;
                endcase
            end
        end else if (valid_e) begin
            // Moves only land when idle so an in-flight result is never overwritten.
            if (mdu_op == MDU_MTHI) hi_d = op_a;
            if (mdu_op == MDU_MTLO) lo_d = op_a;
        end
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= MDU_NONE;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            busy_q <= busy_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;

endmodule

// File: rtl/stage_e_mdu.sv
// Execute stage: operand forwarding, immediate select, 12-op ALU, MDU and result select.
module stage_e_mdu
    import stage_e_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     RD1_E,
    input  logic [WIDTH-1:0]     RD2_E,
    input  logic [WIDTH-1:0]     imm32_E,
    input  logic [WIDTH-1:0]     RFWD_M,
    input  logic [WIDTH-1:0]     RFWD_W,
    input  logic [FWD_SEL_W-1:0] MF_ALUA_Sel,
    input  logic [FWD_SEL_W-1:0] MF_ALUB_Sel,
    input  logic                 BSel,
    input  logic [ALU_OP_W-1:0]  ALUOp,
    input  logic [MDU_OP_W-1:0]  MDUOp,
    input  logic                 Valid_E,
    input  logic [RES_SEL_W-1:0] ResSel,
    output logic [WIDTH-1:0]     C_E,
    output logic [WIDTH-1:0]     RD2_fwd_E,
    output logic                 Busy
);

    localparam int unsigned SH_W = $clog2(WIDTH);

    logic [WIDTH-1:0] a_c, b_c, alu_c, hi, lo;
    logic [SH_W-1:0]  sh_c;

    function automatic logic [WIDTH-1:0] fwd_sel(input logic [WIDTH-1:0]     rd,
                                                 input logic [WIDTH-1:0]     m,
                                                 input logic [WIDTH-1:0]     w,
                                                 input logic [FWD_SEL_W-1:0] sel);
        case (sel)
            FWD_M:   return m;
            FWD_W:   return w;
            default: return rd;
        endcase
    endfunction

    assign a_c       = fwd_sel(RD1_E, RFWD_M, RFWD_W, MF_ALUA_Sel);
    assign RD2_fwd_E = fwd_sel(RD2_E, RFWD_M, RFWD_W, MF_ALUB_Sel);
    assign b_c       = BSel ? imm32_E : RD2_fwd_E;
    assign sh_c      = a_c[SH_W-1:0];

    always_comb begin
        alu_c = '0;
        case (ALUOp)
            ALU_ADD:  alu_c = a_c + b_c;
            ALU_SUB:  alu_c = a_c - b_c;
            ALU_OR:   alu_c = a_c | b_c;
            ALU_AND:  alu_c = a_c & b_c;
            ALU_XOR:  alu_c = a_c ^ b_c;
            ALU_NOR:  alu_c = ~(a_c | b_c);
            ALU_SLT:  alu_c = WIDTH'($signed(a_c) < $signed(b_c));
            ALU_SLTU: alu_c = WIDTH'(a_c < b_c);
            ALU_SLLV: alu_c = b_c << sh_c;
            ALU_SRLV: alu_c = b_c >> sh_c;
            ALU_SRAV: alu_c = WIDTH'($signed(b_c) >>> sh_c);
            ALU_LUI:  alu_c = b_c << (WIDTH / 2);
            default:  alu_c = '0;
        endcase
    end

    mdu_unit #(
        .WIDTH       (WIDTH),
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_mdu (
        .clk     (clk),
        .reset   (reset),
        .valid_e (Valid_E),
        .mdu_op  (MDUOp),
        .op_a    (a_c),
        .op_b    (RD2_fwd_E),
        .hi      (hi),
        .lo      (lo),
        .busy    (Busy)
    );

    // HI/LO are shown as stored, so stale values stay visible while Busy.
    always_comb begin
        case (ResSel)
            RES_HI:  C_E = hi;
            RES_LO:  C_E = lo;
            default: C_E = alu_c;
        endcase
    end

endmodule

// File: tb/tb_stage_e_mdu.sv
// Self-checking bench for stage_e_mdu: ALU/forwarding tables plus an MDU scoreboard.
module tb_stage_e_mdu;
    import stage_e_pkg::*;

    localparam int unsigned W      = 32;
    localparam int          MULT_N = 5;
    localparam int          DIV_N  = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  RD1_E, RD2_E, imm32_E, RFWD_M, RFWD_W;
    logic [1:0]    MF_ALUA_Sel, MF_ALUB_Sel;
    logic          BSel;
    logic [3:0]    ALUOp;
    logic [2:0]    MDUOp;
    logic          Valid_E;
    logic [1:0]    ResSel;
    logic [W-1:0]  C_E, RD2_fwd_E;
    logic          Busy;

    int n_checks = 0;
    int n_fail   = 0;
    int viol_cnt = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    stage_e_mdu #(.WIDTH(W), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .RD1_E(RD1_E), .RD2_E(RD2_E), .imm32_E(imm32_E),
        .RFWD_M(RFWD_M), .RFWD_W(RFWD_W), .MF_ALUA_Sel(MF_ALUA_Sel), .MF_ALUB_Sel(MF_ALUB_Sel),
        .BSel(BSel), .ALUOp(ALUOp), .MDUOp(MDUOp), .Valid_E(Valid_E), .ResSel(ResSel),
        .C_E(C_E), .RD2_fwd_E(RD2_fwd_E), .Busy(Busy)
    );

    always #5 clk = ~clk;

    // Hazard-contract monitor: MDU ops presented while Busy are protocol violations.
    always @(negedge clk) begin
        if (reset && Valid_E && Busy && MDUOp >= MDU_MULT && MDUOp <= MDU_MTLO)
            viol_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] oh, input logic [31:0] ol);
        exp_t        e;
        logic [63:0] p;
        longint      sa, sb, q, r;
        e.hi = oh;
        e.lo = ol;
        e.cyc = DIV_N;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MDU_MULT:  begin p = 64'(sa * sb); e.hi = p[63:32]; e.lo = p[31:0]; e.cyc = MULT_N; end
            MDU_MULTU: begin p = 64'(a) * 64'(b); e.hi = p[63:32]; e.lo = p[31:0]; e.cyc = MULT_N; end
            MDU_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; e.lo = q[31:0]; e.hi = r[31:0]; end
            MDU_DIVU:  if (b != 0) begin e.lo = a / b; e.hi = a % b; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        ResSel = RES_HI;
        #1 h = C_E;
        ResSel = RES_LO;
        #1 l = C_E;
        ResSel = RES_ALU;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        MF_ALUA_Sel = FWD_RD;
        MF_ALUB_Sel = FWD_RD;
        RD1_E   = a;
        RD2_E   = b;
        MDUOp   = op;
        Valid_E = 1'b1;
        tick();
        Valid_E = 1'b0;
        MDUOp   = MDU_NONE;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (Busy === 1'b1 && cyc < 100) begin
            cyc++;
            tick();
        end
        if (cyc >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL busy_timeout: Busy still %b after %0d cycles, required 0", Busy, cyc);
        end
    endtask

    task automatic run_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int cyc, output logic busy1,
                           output logic [31:0] mid_hi, output logic [31:0] mid_lo,
                           output logic [31:0] fin_hi, output logic [31:0] fin_lo);
        issue(op, a, b);
        busy1 = Busy;
        read_hilo(mid_hi, mid_lo);
        wait_idle(cyc);
        read_hilo(fin_hi, fin_lo);
    endtask

    task automatic test_reset();
        logic [31:0] h, l;
        reset = 1'b0;
        tick();
        tick();
        read_hilo(h, l);
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", Busy); end
        n_checks++; if (h !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h required 0", h); end
        n_checks++; if (l !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h required 0", l); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_forwarding();
        typedef struct packed {logic [1:0] sa; logic [1:0] sb; logic bsel; logic [31:0] c; logic [31:0] r2;} fwd_vec_t;
        fwd_vec_t v[5] = '{
            '{2'b10, 2'b00, 1'b1, 32'd8,  32'd100},
            '{2'b10, 2'b01, 1'b0, 32'd12, 32'd7},
            '{2'b01, 2'b01, 1'b0, 32'd14, 32'd7},
            '{2'b11, 2'b10, 1'b0, 32'd6,  32'd5},
            '{2'b00, 2'b11, 1'b0, 32'd101, 32'd100}
        };
        RD1_E = 32'd1; RD2_E = 32'd100; RFWD_M = 32'd5; RFWD_W = 32'd7; imm32_E = 32'd3;
        ALUOp = ALU_ADD; ResSel = RES_ALU;
        foreach (v[i]) begin
            MF_ALUA_Sel = v[i].sa;
            MF_ALUB_Sel = v[i].sb;
            BSel = v[i].bsel;
            #1;
            n_checks++;
            if (C_E !== v[i].c) begin n_fail++; $display("FAIL fwd_c_e[%0d]: got %h required %h", i, C_E, v[i].c); end
            n_checks++;
            if (RD2_fwd_E !== v[i].r2) begin n_fail++; $display("FAIL fwd_rd2[%0d]: got %h required %h", i, RD2_fwd_E, v[i].r2); end
        end
        MF_ALUA_Sel = FWD_RD; MF_ALUB_Sel = FWD_RD; BSel = 1'b0;
    endtask

    task automatic test_alu();
        typedef struct packed {logic [3:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] e;} alu_vec_t;
        alu_vec_t v[14] = '{
            '{4'd0,  32'd5,         32'd3,         32'd8},
            '{4'd1,  32'd3,         32'd5,         32'hFFFF_FFFE},
            '{4'd2,  32'hF0,        32'h0F,        32'hFF},
            '{4'd3,  32'hFF,        32'h0F,        32'h0F},
            '{4'd4,  32'hFF,        32'h0F,        32'hF0},
            '{4'd5,  32'h0,         32'h0,         32'hFFFF_FFFF},
            '{4'd6,  32'hFFFF_FFFF, 32'd1,         32'd1},
            '{4'd7,  32'hFFFF_FFFF, 32'd1,         32'd0},
            '{4'd8,  32'd4,         32'd1,         32'h10},
            '{4'd9,  32'd4,         32'h8000_0000, 32'h0800_0000},
            '{4'd10, 32'd31,        32'h8000_0000, 32'hFFFF_FFFF},
            '{4'd10, 32'h21,        32'h8000_0000, 32'hC000_0000},
            '{4'd11, 32'd0,         32'h1234,      32'h1234_0000},
            '{4'd13, 32'd5,         32'd3,         32'd0}
        };
        MF_ALUA_Sel = FWD_RD; MF_ALUB_Sel = FWD_RD; BSel = 1'b0; ResSel = RES_ALU;
        foreach (v[i]) begin
            ALUOp = v[i].op;
            RD1_E = v[i].a;
            RD2_E = v[i].b;
            #1;
            n_checks++;
            if (C_E !== v[i].e) begin n_fail++; $display("FAIL alu_op%0d[%0d]: got %h required %h", v[i].op, i, C_E, v[i].e); end
        end
        ALUOp = ALU_LUI; BSel = 1'b1; imm32_E = 32'h0000_ABCD; RD2_E = 32'h1;
        #1;
        n_checks++;
        if (C_E !== 32'hABCD_0000) begin n_fail++; $display("FAIL alu_lui_imm: got %h required abcd0000", C_E); end
        BSel = 1'b0; ALUOp = ALU_ADD;
        tick();
    endtask

    task automatic check_mdu_vectors(input string tag, input logic [2:0] ops[], input logic [31:0] as[], input logic [31:0] bs[]);
        logic [31:0] oh, ol, mh, ml, fh, fl;
        logic        b1;
        int          cyc;
        exp_t        e;
        foreach (ops[i]) begin
            read_hilo(oh, ol);
            exp_q.push_back(model(ops[i], as[i], bs[i], oh, ol));
            run_mdu(ops[i], as[i], bs[i], cyc, b1, mh, ml, fh, fl);
            e = exp_q.pop_front();
            n_checks++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL %s[%0d]_busy_start: got %b required 1", tag, i, b1); end
            n_checks++; if (cyc != e.cyc) begin n_fail++; $display("FAIL %s[%0d]_busy_cycles: got %0d required %0d", tag, i, cyc, e.cyc); end
            n_checks++; if ({mh, ml} !== {oh, ol}) begin n_fail++; $display("FAIL %s[%0d]_stale: got %h_%h required %h_%h", tag, i, mh, ml, oh, ol); end
            n_checks++; if (fh !== e.hi) begin n_fail++; $display("FAIL %s[%0d]_hi: got %h required %h", tag, i, fh, e.hi); end
            n_checks++; if (fl !== e.lo) begin n_fail++; $display("FAIL %s[%0d]_lo: got %h required %h", tag, i, fl, e.lo); end
        end
    endtask

    task automatic test_mult();
        logic [2:0]  ops[] = '{MDU_MULT, MDU_MULTU, MDU_MULT, MDU_MULTU};
        logic [31:0] as[]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, $urandom, $urandom};
        logic [31:0] bs[]  = '{32'd7, 32'hFFFF_FFFF, $urandom, $urandom};
        logic [31:0] h, l;
        check_mdu_vectors("mult", ops, as, bs);
        issue(MDU_MULT, 32'hFFFF_FFFD, 32'd7);
        for (int k = 0; k < MULT_N; k++) tick();
        read_hilo(h, l);
        n_checks++; if ({h, l} !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_fail++; $display("FAIL mult_neg3x7: got %h_%h required ffffffff_ffffffeb", h, l); end
    endtask

    task automatic test_div();
        logic [2:0]  ops[] = '{MDU_DIV, MDU_DIV, MDU_DIVU, MDU_DIVU, MDU_DIV, MDU_DIV};
        logic [31:0] as[]  = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd9, $urandom, 32'd7, $urandom};
        logic [31:0] bs[]  = '{32'd2, 32'hFFFF_FFFF, 32'd0, $urandom_range(1, 5000), 32'hFFFF_FFFE, $urandom};
        check_mdu_vectors("div", ops, as, bs);
    endtask

    task automatic test_back_to_back();
        logic [31:0] h, l, oh, ol;
        int          v0, cyc;
        exp_t        e;
        v0 = viol_cnt;
        read_hilo(oh, ol);
        exp_q.push_back(model(MDU_MULT, 32'd11, 32'd13, oh, ol));
        issue(MDU_MULT, 32'd11, 32'd13);
        issue(MDU_MULT, 32'd2, 32'd2);
        issue(MDU_MTHI, 32'hDEAD, 32'd0);
        wait_idle(cyc);
        read_hilo(h, l);
        e = exp_q.pop_front();
        n_checks++; if (cyc + 2 != e.cyc) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d required %0d", cyc + 2, e.cyc); end
        n_checks++; if ({h, l} !== {e.hi, e.lo}) begin n_fail++; $display("FAIL b2b_result: got %h_%h required %h_%h", h, l, e.hi, e.lo); end
        n_checks++; if (viol_cnt - v0 != 2) begin n_fail++; $display("FAIL b2b_hazard_monitor: got %0d required 2", viol_cnt - v0); end
        tick();
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL b2b_no_queue: got Busy %b required 0", Busy); end
    endtask

    task automatic test_bubble();
        logic [31:0] oh, ol, h, l;
        read_hilo(oh, ol);
        RD1_E = 32'd5; RD2_E = 32'd6; MDUOp = MDU_MULT; Valid_E = 1'b0;
        tick();
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL bubble_busy: got %b required 0", Busy); end
        MDUOp = MDU_MTLO;
        tick();
        MDUOp = MDU_NONE;
        read_hilo(h, l);
        n_checks++; if ({h, l} !== {oh, ol}) begin n_fail++; $display("FAIL bubble_hilo: got %h_%h required %h_%h", h, l, oh, ol); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] h, l;
        issue(MDU_DIV, 32'd100, 32'd7);
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        read_hilo(h, l);
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b required 0", Busy); end
        n_checks++; if ({h, l} !== 64'h0) begin n_fail++; $display("FAIL rst_mid_hilo: got %h_%h required 0_0", h, l); end
        issue(MDU_MTLO, 32'h55, 32'd0);
        ResSel = RES_LO;
        #1;
        n_checks++; if (C_E !== 32'h55) begin n_fail++; $display("FAIL mtlo_after_rst: got %h required 55", C_E); end
        ResSel = RES_ALU;
        for (int k = 0; k < DIV_N + 2; k++) tick();
        read_hilo(h, l);
        n_checks++; if ({h, l} !== 64'h0000_0000_0000_0055) begin n_fail++; $display("FAIL rst_discard: got %h_%h required 0_55", h, l); end
    endtask

    initial begin
        reset = 1'b0;
        RD1_E = '0; RD2_E = '0; imm32_E = '0; RFWD_M = '0; RFWD_W = '0;
        MF_ALUA_Sel = FWD_RD; MF_ALUB_Sel = FWD_RD; BSel = 1'b0;
        ALUOp = ALU_ADD; MDUOp = MDU_NONE; Valid_E = 1'b0; ResSel = RES_ALU;
        test_reset();
        test_forwarding();
        test_alu();
        test_mult();
        test_div();
        test_back_to_back();
        test_bubble();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_e_mdu.md
Name: stage_e_mdu

Overview:
- Parametrised successor of the execute stage, sitting in the E pipeline stage between the ID/EX and EX/MEM registers.
- Keeps the M/W operand forwarding, the immediate select and the combinational ALU, with the ALU widened to 12 operations.
- Adds a multi-cycle multiply/divide unit (MDU) with HI/LO registers, a Busy handshake to the hazard unit, and a result-select mux.

Parameters:
WIDTH, 32, datapath width (even, >=8)
MULT_CYCLES, 5, cycles Busy stays high for mult/multu (>=1)
DIV_CYCLES, 10, cycles Busy stays high for div/divu (>=1)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset (0 = reset)
RD1_E  in  WIDTH  rs value from ID/EX register
RD2_E  in  WIDTH  rt value from ID/EX register
imm32_E  in  WIDTH  extended immediate
RFWD_M  in  WIDTH  forwarded value from M stage
RFWD_W  in  WIDTH  forwarded value from W stage
MF_ALUA_Sel  in  2  10=RFWD_M, 01=RFWD_W, else RD1_E
MF_ALUB_Sel  in  2  same encoding, applied to RD2_E
BSel  in  1  0=forwarded rt, 1=imm32_E as ALU B
ALUOp  in  4  ALU operation
MDUOp  in  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none
Valid_E  in  1  E holds a real instruction, not a bubble
ResSel  in  2  00 ALU, 01 HI, 10 LO, 11 ALU
C_E  out  WIDTH  selected result
RD2_fwd_E  out  WIDTH  forwarded rt, used as store data
Busy  out  1  MDU operation in flight

Behaviour:
- Forwarding: A = fwd(RD1_E, MF_ALUA_Sel); RD2_fwd_E = fwd(RD2_E, MF_ALUB_Sel); B = BSel ? imm32_E : RD2_fwd_E. Purely combinational.
- ALU (combinational, results mod 2^WIDTH; sh = A[log2(WIDTH)-1:0]):
  - 0 add, 1 sub, 2 or, 3 and, 4 xor, 5 nor
  - 6 slt (signed, result 1/0), 7 sltu
  - 8 sllv B<<sh, 9 srlv B>>sh, 10 srav B>>>sh
  - 11 lui B<<(WIDTH/2)
  - 12..15 produce 0
- C_E = ALU, HI or LO per ResSel. It shows the current register contents, so stale values are visible while Busy.
- Start condition: start = Valid_E & reset & MDUOp in {001..100} & !Busy.
  - On the start edge, operands A and RD2_fwd_E are latched and a counter is loaded with MULT_CYCLES or DIV_CYCLES.
  - Busy = (counter != 0), registered. Busy is high for exactly N cycles after the start edge.
  - On the edge where the counter goes 1->0, HI/LO are written. The new HI/LO are readable in the first cycle with Busy=0.
- mult: signed {HI,LO} = A*B (2*WIDTH bits). multu: unsigned.
- div: LO = quotient truncated toward zero, HI = remainder with the dividend's sign.
  - Signed overflow (MIN / -1): LO = MIN, HI = 0.
  - divu: unsigned.
  - Divisor 0 (either div op): HI/LO unchanged; Busy still runs its full DIV_CYCLES.
- mthi/mtlo with Valid_E: write A to HI/LO at the edge; no Busy.
  - Ignored while Busy, since the in-flight result must win.
  - The hazard unit guarantees this case never occurs; the bench asserts it.
- Start request while Busy: ignored. No queueing; the bench asserts it never happens.
- Hazard contract: the hazard unit stalls D when (Busy | start) and D holds an MDU or mfhi/mflo instruction. This block does not stall itself.
- Reset (reset=0 at an edge), including mid-operation: HI=0, LO=0, counter=0, Busy=0, latched operands=0. The in-flight result is discarded.
- Valid_E=0: no state change, whatever MDUOp says.
- Combinational outputs have no reset value. Busy reads 0 one edge after reset is asserted.

Decomposition:
- Shared package stage_e_pkg:
  - ALUOp localparams (ALU_ADD..ALU_LUI)
  - MDUOp localparams
  - ResSel codes (RES_ALU, RES_HI, RES_LO)
  - forwarding codes (FWD_RD=00, FWD_W=01, FWD_M=10)
- One sub-module, mdu_unit: counter, operand latches, HI/LO, Busy, result compute. Parameters WIDTH, MULT_CYCLES, DIV_CYCLES.
- The forwarding muxes and ALU stay in stage_e_mdu.

Test Plan:
- Forwarding priority: RD1_E=1, RFWD_M=5, RFWD_W=7, MF_ALUA_Sel=10, ALUOp=add, BSel=1, imm=3 -> C_E=8. MF_ALUB_Sel=01, BSel=0 -> RD2_fwd_E=7.
- ALU edges: slt(0xFFFFFFFF,1)=1; sltu(0xFFFFFFFF,1)=0; srav(0x80000000, sh=31)=0xFFFFFFFF; lui(0x1234)=0x12340000; ALUOp=13 -> 0.
- mult A=-3, B=7 at edge 0 -> Busy high for cycles 1..5; HI/LO unchanged until then; then HI=0xFFFFFFFF, LO=0xFFFFFFEB, Busy=0. multu 0xFFFFFFFF^2 -> HI=0xFFFFFFFE, LO=1.
- div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 cycles. div 0x80000000/-1 -> LO=0x80000000, HI=0. divu 9/0 -> HI/LO unchanged, Busy still 10 cycles.
- reset=0 asserted at cycle 3 of a div -> next cycle Busy=0, HI=LO=0. A following mtlo A=0x55 -> ResSel=10 gives C_E=0x55 the next cycle.
- Valid_E=0 with MDUOp=mult -> Busy stays 0, HI/LO unchanged. A second mult issued while Busy -> ignored and the assertion fires.
